// File: rtl/rs_gf8_pkg.sv
// rtl/rs_gf8_pkg.sv - GF(8) constants, alpha table and constant-multiply helper for RS(7,3)
package rs_gf8_pkg;

    localparam int SYM_W = 3;
    localparam int N_SYM = 7;
    localparam int K_SYM = 3;
    localparam int N_SYN = N_SYM - K_SYM;
    localparam int CW_W  = SYM_W * N_SYM;

    localparam logic [SYM_W-1:0] ALPHA_POW [0:N_SYM-1] =
        '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101};

    typedef enum logic {IDLE, RUN} state_t;

    // pow is always a constant at the call site, so this folds into a fixed XOR network.
    function automatic logic [SYM_W-1:0] gf8_mul_alpha_pow(input logic [SYM_W-1:0] sym,
                                                           input int pow);
        logic [SYM_W-1:0] c;
        logic [SYM_W-1:0] s;
        logic [SYM_W-1:0] prod;
        c    = ALPHA_POW[pow % N_SYM];
        s    = sym;
        prod = '0;
        for (int b = 0; b < SYM_W; b++) begin
            if (c[b]) prod = prod ^ s;
            s = {s[1], s[0] ^ s[2], s[2]};
        end
        return prod;
    endfunction

endpackage

// File: rtl/rs_syndrome_cell.sv
// rtl/rs_syndrome_cell.sv - one Horner accumulator evaluating r(x) at a^POW
module rs_syndrome_cell
    import rs_gf8_pkg::*;
#(
    parameter int POW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             step,
    input  logic [SYM_W-1:0] sym_in,
    output logic [SYM_W-1:0] acc_next
);

    logic [SYM_W-1:0] acc;

    assign acc_next = gf8_mul_alpha_pow(acc, POW) ^ sym_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (enable) begin
            if (clear) begin
                acc <= '0;
            end else if (step) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - RS(7,3) syndrome calculator: FSM, symbol shifter and four Horner cells
module rs_syndrome_calc
    import rs_gf8_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [20:0]             codeword,
    output logic                    out_valid,
    output logic [11:0]             syndromes,
    output logic                    error_detected
);

    state_t           state_q;
    state_t           next_state;
    logic [2:0]       count;
    logic [CW_W-1:0]  shreg;
    logic             accept;
    logic             step;
    logic             done;
    logic [SYM_W-1:0] syn_next [N_SYN];
    logic [11:0]      syn_flat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (enable) begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        in_ready   = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (count == 3'd6) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Cells see the top symbol; r6 is consumed first so Horner ends on r0.
    for (genvar j = 0; j < N_SYN; j++) begin : g_cell
        rs_syndrome_cell #(.POW(j + 1)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .clear    (accept),
            .step     (step),
            .sym_in   (shreg[CW_W-1 -: SYM_W]),
            .acc_next (syn_next[j])
        );
    end

    assign syn_flat = {syn_next[3], syn_next[2], syn_next[1], syn_next[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            count          <= '0;
            shreg          <= '0;
            out_valid      <= 1'b0;
            syndromes      <= '0;
            error_detected <= 1'b0;
        end else if (enable) begin
            out_valid <= done;
            if (accept) begin
                shreg <= codeword;
                count <= '0;
            end else if (step) begin
                shreg <= {shreg[CW_W-SYM_W-1:0], {SYM_W{1'b0}}};
                count <= done ? 3'd0 : count + 3'd1;
            end
            if (done) begin
                syndromes      <= syn_flat;
                error_detected <= |syn_flat;
            end
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb/tb_rs_syndrome_calc.sv - scoreboard bench for rs_syndrome_calc
module tb_rs_syndrome_calc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] codeword = '0;
    logic        out_valid;
    logic [11:0] syndromes;
    logic        error_detected;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [12:0] sbq [$];
    logic last_edge_en = 1'b0;
    logic prev_ov = 1'b0;

    logic [2:0] exp_t [0:6] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
    int         log_t [0:7] = '{0, 0, 1, 3, 2, 6, 4, 5};

    rs_syndrome_calc dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword       (codeword),
        .out_valid      (out_valid),
        .syndromes      (syndromes),
        .error_detected (error_detected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Direct-sum evaluation through log/antilog tables.
    function automatic logic [12:0] model(input logic [20:0] cw);
        logic [11:0] syn;
        logic [2:0]  s;
        logic [2:0]  sym;
        syn = '0;
        for (int j = 1; j <= 4; j++) begin
            s = '0;
            for (int i = 0; i < 7; i++) begin
                sym = cw[3*i +: 3];
                if (sym != 0) s = s ^ exp_t[(log_t[sym] + i * j) % 7];
            end
            syn[3*(j-1) +: 3] = s;
        end
        return {|syn, syn};
    endfunction

    always @(posedge clk) last_edge_en <= enable && !reset;

    always @(negedge clk) begin
        if (last_edge_en) begin
            if (out_valid) begin
                chk("ov_pulse", {31'd0, prev_ov}, 32'd0);
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    logic [12:0] e;
                    e = sbq.pop_front();
                    chk("syndromes", {19'd0, error_detected, syndromes}, {19'd0, e});
                end
                prev_ov = 1'b1;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    task automatic send(input logic [20:0] cw, input logic [12:0] e, input bit expect_out);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 32'd1, 32'd0);
        codeword = cw;
        in_valid = 1'b1;
        if (expect_out) sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || !in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        logic [20:0] cw;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_syndromes", {20'd0, syndromes}, 32'd0);
        chk("rst_error", {31'd0, error_detected}, 32'd0);

        // Case 1: all-zero word, with latency measured from the accept edge.
        send(21'h0, 13'h0000, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency_edges", n, 32'd7);
        wait_drain();

        send(21'h01653, 13'h0000, 1);
        wait_drain();
        send(21'h0165B, {1'b1, 12'hCE2}, 1);
        wait_drain();
        chk("hold_syndromes", {20'd0, syndromes}, 32'hCE2);
        chk("hold_error", {31'd0, error_detected}, 32'd1);

        // Case 4 with a back-to-back accept in the out_valid cycle.
        send(21'h000001, {1'b1, 12'h249}, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        codeword = 21'h01653;
        in_valid = 1'b1;
        sbq.push_back(13'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_busy", {31'd0, in_ready}, 32'd0);
        wait_drain();

        // Case 5: stalls during RUN.
        send(21'h0165B, {1'b1, 12'hCE2}, 1);
        for (int k = 0; k < 24; k++) begin
            enable = ~enable;
            @(negedge clk);
        end
        enable = 1'b1;
        wait_drain();

        // Case 6: reset mid-RUN aborts.
        send(21'h000001, 13'h0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_syndromes", {20'd0, syndromes}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (12) @(negedge clk);
        send(21'h0165B, {1'b1, 12'hCE2}, 1);
        wait_drain();

        // in_valid during RUN must be ignored.
        send(21'h0165B, {1'b1, 12'hCE2}, 1);
        codeword = 21'h000001;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        chk("ignore_busy_syn", {20'd0, syndromes}, 32'hCE2);

        for (int k = 0; k < 1000; k++) begin
            cw = 21'($urandom);
            if (k % 10 == 0) cw = 21'h0165B ^ (21'd1 << $urandom_range(20));
            send(cw, model(cw), 1);
        end
        wait_drain();
        chk("sb_drained", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
